// File: rtl/trng_seed_collector.sv
// trng_seed_collector: pulls words from a TRNG over a request/ready handshake and packs them
// into a cipher seed, with repetition and response-timeout health checks.
module trng_seed_collector #(
    parameter int NUM_WORDS = 12,
    parameter int ZERO_CTR  = 1,
    parameter int REP_LIMIT = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     err_timeout,
    output logic [32*NUM_WORDS-1:0]  seed_out,
    output logic [7:0]               words_done,
    output logic                     trng_request,
    input  logic                     trng_ready,
    input  logic [31:0]              trng_data
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_ERROR   = 2'd3;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);
    localparam logic [7:0]    TARGET  = 8'(NUM_WORDS - ZERO_CTR);

    logic [1:0]              state_q, state_d;
    logic [32*NUM_WORDS-1:0] seed_q, seed_d;
    logic [7:0]              wd_q, wd_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [RW-1:0]           rep_q, rep_d;
    logic [31:0]             prev_q, prev_d;
    logic                    have_prev_q, have_prev_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    errto_q, errto_d;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        wd_d        = wd_q;
        tmo_d       = tmo_q;
        rep_d       = rep_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        done_d      = 1'b0;
        error_d     = error_q;
        errto_d     = errto_q;
        if (state_q != S_COLLECT && start) begin
            state_d     = S_COLLECT;
            seed_d      = '0;
            wd_d        = '0;
            tmo_d       = '0;
            rep_d       = '0;
            have_prev_d = 1'b0;
            error_d     = 1'b0;
            errto_d     = 1'b0;
        end else if (state_q == S_COLLECT) begin
            if (trng_ready) begin
                tmo_d = '0;
                // first word of a run has no predecessor, so it is never a repeat
                if (have_prev_q && trng_data == prev_q) begin
                    rep_d = rep_q + 1'b1;
                    if (rep_d == REP_MAX) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        errto_d = 1'b0;
                    end
                end else begin
                    rep_d       = '0;
                    prev_d      = trng_data;
                    have_prev_d = 1'b1;
                    wd_d        = wd_q + 8'd1;
                    for (int i = 0; i < NUM_WORDS; i++)
                        if (wd_q == 8'(i)) seed_d[32*i +: 32] = trng_data;
                    if (wd_d == TARGET) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_d == TMO_MAX) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                    errto_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            wd_q        <= '0;
            tmo_q       <= '0;
            rep_q       <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            errto_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            wd_q        <= wd_d;
            tmo_q       <= tmo_d;
            rep_q       <= rep_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            done_q      <= done_d;
            error_q     <= error_d;
            errto_q     <= errto_d;
        end
    end

    assign busy         = state_q == S_COLLECT;
    assign trng_request = state_q == S_COLLECT;
    assign done         = done_q;
    assign error        = error_q;
    assign err_timeout  = errto_q;
    assign seed_out     = seed_q;
    assign words_done   = wd_q;
endmodule

// File: tb/tb_trng_seed_collector.sv
// tb_trng_seed_collector: directed scenario tasks for the TRNG seed collector.
module tb_trng_seed_collector;
    localparam int NW = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             trng_ready = 1'b0;
    logic [31:0]      trng_data = '0;
    logic             busy, done, error, err_timeout, trng_request;
    logic [32*NW-1:0] seed_out;
    logic [7:0]       words_done;
    int               vecs = 0;
    int               errs = 0;

    always #5 clk = ~clk;

    trng_seed_collector dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .err_timeout(err_timeout), .seed_out(seed_out), .words_done(words_done),
        .trng_request(trng_request), .trng_ready(trng_ready), .trng_data(trng_data)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", done); end
        vecs++; if (error !== 1'b0) begin errs++; $display("FAIL rst_error got %b want 0", error); end
        vecs++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL rst_errto got %b want 0", err_timeout); end
        vecs++; if (trng_request !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", trng_request); end
        vecs++; if (seed_out !== '0) begin errs++; $display("FAIL rst_seed got %h want 0", seed_out); end
        vecs++; if (words_done !== 8'd0) begin errs++; $display("FAIL rst_words got %0d want 0", words_done); end
        rst = 1'b1;
        tick();
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_fill();
        logic [31:0] exp;
        trng_ready = 1'b1;
        do_start();
        vecs++; if (trng_request !== 1'b1) begin errs++; $display("FAIL fill_req1 got %b want 1", trng_request); end
        for (int k = 1; k <= 11; k++) begin
            trng_data = 32'(k);
            vecs++; if (done !== 1'b0) begin errs++; $display("FAIL fill_early_done cyc %0d got %b want 0", k, done); end
            tick();
        end
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL fill_done got %b want 1", done); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL fill_busy got %b want 0", busy); end
        vecs++; if (trng_request !== 1'b0) begin errs++; $display("FAIL fill_req got %b want 0", trng_request); end
        vecs++; if (words_done !== 8'd11) begin errs++; $display("FAIL fill_words got %0d want 11", words_done); end
        for (int i = 0; i < NW; i++) begin
            exp = (i < 11) ? 32'(i + 1) : 32'd0;
            vecs++; if (seed_out[32*i +: 32] !== exp) begin errs++; $display("FAIL fill_word%0d got %h want %h", i, seed_out[32*i +: 32], exp); end
        end
        trng_ready = 1'b0;
        tick();
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL fill_done_pulse got %b want 0", done); end
        vecs++; if (seed_out[32*5 +: 32] !== 32'd6) begin errs++; $display("FAIL fill_hold got %h want 6", seed_out[32*5 +: 32]); end
    endtask

    task automatic test_toggle();
        do_start();
        for (int k = 0; k <= 20; k++) begin
            trng_ready = (k % 2 == 0);
            trng_data = 32'(100 + k);
            vecs++; if (done !== 1'b0) begin errs++; $display("FAIL tog_early_done cyc %0d got %b want 0", k + 1, done); end
            tick();
        end
        trng_ready = 1'b0;
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL tog_done got %b want 1", done); end
        vecs++; if (words_done !== 8'd11) begin errs++; $display("FAIL tog_words got %0d want 11", words_done); end
        vecs++; if (seed_out[31:0] !== 32'd100) begin errs++; $display("FAIL tog_word0 got %0d want 100", seed_out[31:0]); end
        vecs++; if (seed_out[32*10 +: 32] !== 32'd120) begin errs++; $display("FAIL tog_word10 got %0d want 120", seed_out[32*10 +: 32]); end
    endtask

    task automatic test_repeat();
        logic [31:0] seq [6];
        seq = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'h12345678};
        trng_ready = 1'b1;
        trng_data = 32'hDEADBEEF;
        do_start();
        for (int k = 1; k <= 4; k++) begin
            vecs++; if (error !== 1'b0) begin errs++; $display("FAIL rep_early_err cyc %0d got %b want 0", k, error); end
            tick();
        end
        trng_ready = 1'b0;
        vecs++; if (error !== 1'b1) begin errs++; $display("FAIL rep_err got %b want 1", error); end
        vecs++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL rep_cause got %b want 0", err_timeout); end
        vecs++; if (words_done !== 8'd1) begin errs++; $display("FAIL rep_words got %0d want 1", words_done); end
        vecs++; if (trng_request !== 1'b0) begin errs++; $display("FAIL rep_req got %b want 0", trng_request); end
        vecs++; if (seed_out[31:0] !== 32'hDEADBEEF) begin errs++; $display("FAIL rep_partial got %h want deadbeef", seed_out[31:0]); end
        trng_ready = 1'b1;
        do_start();
        vecs++; if (error !== 1'b0) begin errs++; $display("FAIL rep_err_clear got %b want 0", error); end
        for (int k = 0; k < 6; k++) begin
            trng_data = seq[k];
            tick();
        end
        trng_ready = 1'b0;
        vecs++; if (words_done !== 8'd2) begin errs++; $display("FAIL rep2_words got %0d want 2", words_done); end
        vecs++; if (error !== 1'b0) begin errs++; $display("FAIL rep2_err got %b want 0", error); end
        vecs++; if (seed_out[63:32] !== 32'h12345678) begin errs++; $display("FAIL rep2_word1 got %h want 12345678", seed_out[63:32]); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rep2_abort got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        trng_ready = 1'b0;
        do_start();
        repeat (1023) tick();
        vecs++; if (error !== 1'b0) begin errs++; $display("FAIL tmo_early got %b want 0", error); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL tmo_busy got %b want 1", busy); end
        tick();
        vecs++; if (error !== 1'b1) begin errs++; $display("FAIL tmo_err got %b want 1", error); end
        vecs++; if (err_timeout !== 1'b1) begin errs++; $display("FAIL tmo_cause got %b want 1", err_timeout); end
        vecs++; if (trng_request !== 1'b0) begin errs++; $display("FAIL tmo_req got %b want 0", trng_request); end
    endtask

    task automatic test_reset_mid();
        trng_ready = 1'b1;
        do_start();
        vecs++; if (error !== 1'b0) begin errs++; $display("FAIL mid_err_clear got %b want 0", error); end
        vecs++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL mid_errto_clear got %b want 0", err_timeout); end
        for (int k = 1; k <= 4; k++) begin
            trng_data = 32'(16 + k);
            tick();
        end
        vecs++; if (words_done !== 8'd4) begin errs++; $display("FAIL mid_words4 got %0d want 4", words_done); end
        trng_data = 32'd21;
        rst = 1'b0;
        tick();
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy got %b want 0", busy); end
        vecs++; if (trng_request !== 1'b0) begin errs++; $display("FAIL mid_req got %b want 0", trng_request); end
        vecs++; if (words_done !== 8'd0) begin errs++; $display("FAIL mid_words got %0d want 0", words_done); end
        vecs++; if (seed_out !== '0) begin errs++; $display("FAIL mid_seed got %h want 0", seed_out); end
        rst = 1'b1;
        trng_ready = 1'b0;
        repeat (3) begin
            vecs++; if (done !== 1'b0) begin errs++; $display("FAIL mid_no_done got %b want 0", done); end
            tick();
        end
        trng_ready = 1'b1;
        do_start();
        for (int k = 1; k <= 11; k++) begin
            trng_data = 32'(512 + k);
            tick();
        end
        trng_ready = 1'b0;
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL mid_new_done got %b want 1", done); end
        vecs++; if (seed_out[31:0] !== 32'h201) begin errs++; $display("FAIL mid_new_w0 got %h want 201", seed_out[31:0]); end
        vecs++; if (seed_out[32*10 +: 32] !== 32'h20B) begin errs++; $display("FAIL mid_new_w10 got %h want 20b", seed_out[32*10 +: 32]); end
        vecs++; if (seed_out[32*11 +: 32] !== 32'h0) begin errs++; $display("FAIL mid_new_w11 got %h want 0", seed_out[32*11 +: 32]); end
    endtask

    task automatic test_start_ignored();
        trng_ready = 1'b1;
        do_start();
        for (int k = 1; k <= 11; k++) begin
            trng_data = 32'(768 + k);
            start = (k == 3);
            tick();
        end
        start = 1'b0;
        trng_ready = 1'b0;
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL ign_done got %b want 1", done); end
        vecs++; if (words_done !== 8'd11) begin errs++; $display("FAIL ign_words got %0d want 11", words_done); end
        vecs++; if (seed_out[32*2 +: 32] !== 32'h303) begin errs++; $display("FAIL ign_w2 got %h want 303", seed_out[32*2 +: 32]); end
        tick();
        vecs++; if (seed_out[31:0] !== 32'h301) begin errs++; $display("FAIL ign_hold got %h want 301", seed_out[31:0]); end
        do_start();
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL restart_busy got %b want 1", busy); end
        vecs++; if (seed_out !== '0) begin errs++; $display("FAIL restart_seed got %h want 0", seed_out); end
        vecs++; if (words_done !== 8'd0) begin errs++; $display("FAIL restart_words got %0d want 0", words_done); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        tick();
        test_reset();
        test_fill();
        test_toggle();
        test_repeat();
        test_timeout();
        test_reset_mid();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
